// File: rtl/stager_pkg.sv
// Shared constants and types for the operand stager.
// Row-select encoding and the words-per-row helper.
package stager_pkg;

    localparam int STG_IN_W   = 32;
    localparam int STG_DATA_W = 16;
    localparam int STG_LANES  = 16;
    localparam int STG_DEPTH  = 4;

    typedef enum logic {
        ROW_H = 1'b0,
        ROW_V = 1'b1
    } row_sel_e;

    function automatic int words_per_row(input int row_w, input int in_w);
        return row_w / in_w;
    endfunction

endpackage

// File: rtl/stager_pair_fifo.sv
// DEPTH-entry FIFO of H/V row pairs with occupancy level.
// Head rows read as zero whenever the FIFO is empty.
module stager_pair_fifo #(
    parameter int ROW_W = 256,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ROW_W-1:0]           push_h,
    input  logic [ROW_W-1:0]           push_v,
    input  logic                       pop,
    output logic [ROW_W-1:0]           head_h,
    output logic [ROW_W-1:0]           head_v,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stager_pair_fifo: DEPTH must be a power of 2, >= 2");
    end

    logic [ROW_W-1:0] mem_h [DEPTH];
    logic [ROW_W-1:0] mem_v [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (level != LW'(DEPTH));
    assign do_pop  = pop && (level != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_h[wr_ptr] <= push_h;
            mem_v[wr_ptr] <= push_v;
        end
    end

    // Power-of-2 depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head_h = (level != '0) ? mem_h[rd_ptr] : '0;
    assign head_v = (level != '0) ? mem_v[rd_ptr] : '0;

endmodule

// File: rtl/operand_stager.sv
// Packs load words into H/V row pairs and queues them for the PE array.
// Define STAGER_OVF_CNT_EN to add a saturating dropped-word counter.
module operand_stager
    import stager_pkg::*;
#(
    parameter int IN_W   = STG_IN_W,
    parameter int DATA_W = STG_DATA_W,
    parameter int LANES  = STG_LANES,
    parameter int DEPTH  = STG_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_en_i,
    input  logic [IN_W-1:0]            load_payload_i,
    input  logic                       load_last_i,
    output logic                       load_rdy_o,
    input  logic                       read_en_i,
    output logic                       pair_valid_o,
    output logic [LANES*DATA_W-1:0]    h_bus_o,
    output logic [LANES*DATA_W-1:0]    v_bus_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
`ifdef STAGER_OVF_CNT_EN
    output logic [15:0]                ovf_cnt_o,
`endif
    output logic                       ovf_o
);

    localparam int ROW_W = LANES * DATA_W;
    localparam int WPR   = words_per_row(ROW_W, IN_W);
    localparam int CW    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int LW    = $clog2(DEPTH+1);

    if ((ROW_W % IN_W) != 0 || WPR < 1) begin : g_bad_wpr
        $error("operand_stager: ROW_W must be a positive multiple of IN_W");
    end

    row_sel_e         row_sel;
    logic [CW-1:0]    word_cnt;
    logic [ROW_W-1:0] h_stage;
    logic [ROW_W-1:0] v_stage;
    logic [ROW_W-1:0] h_fill;
    logic [ROW_W-1:0] v_fill;
    logic [LW-1:0]    level;
    logic             accept;
    logic             drop;
    logic             row_end;
    logic             push;

    assign load_rdy_o = (level < LW'(DEPTH));
    assign accept     = load_en_i && load_rdy_o;
    assign drop       = load_en_i && !load_rdy_o;
    assign row_end    = (word_cnt == CW'(WPR - 1));
    assign push       = accept && (load_last_i || (row_end && row_sel == ROW_V));

    // Unwritten slots are still zero, so a flushed pair is zero-filled for free.
    always_comb begin
        h_fill = h_stage;
        v_fill = v_stage;
        for (int i = 0; i < WPR; i++) begin
            if (accept && word_cnt == CW'(i)) begin
                if (row_sel == ROW_H) h_fill[i*IN_W +: IN_W] = load_payload_i;
                else                  v_fill[i*IN_W +: IN_W] = load_payload_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sel  <= ROW_H;
            word_cnt <= '0;
            h_stage  <= '0;
            v_stage  <= '0;
            ovf_o    <= 1'b0;
        end else begin
            if (push) begin
                row_sel  <= ROW_H;
                word_cnt <= '0;
                h_stage  <= '0;
                v_stage  <= '0;
            end else if (accept) begin
                h_stage <= h_fill;
                v_stage <= v_fill;
                if (row_end) begin
                    word_cnt <= '0;
                    row_sel  <= ROW_V;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            if (drop) ovf_o <= 1'b1;
        end
    end

`ifdef STAGER_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_cnt_o <= '0;
        else if (drop && ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
`endif

    stager_pair_fifo #(
        .ROW_W (ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .push_h (h_fill),
        .push_v (v_fill),
        .pop    (read_en_i),
        .head_h (h_bus_o),
        .head_v (v_bus_o),
        .level  (level)
    );

    assign level_o      = level;
    assign pair_valid_o = (level != '0);

endmodule

// File: tb/tb_operand_stager.sv
// Self-checking bench for operand_stager: vector table, directed corners,
// and random traffic against a word-queue reference model.
module tb_operand_stager;

    localparam int IN_W  = 32;
    localparam int ROW_W = 256;
    localparam int WPR   = ROW_W / IN_W;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_en = 1'b0;
    logic [IN_W-1:0]  load_payload = '0;
    logic             load_last = 1'b0;
    logic             load_rdy;
    logic             read_en = 1'b0;
    logic             pair_valid;
    logic [ROW_W-1:0] h_bus;
    logic [ROW_W-1:0] v_bus;
    logic [2:0]       level;
    logic             ovf;
`ifdef STAGER_OVF_CNT_EN
    logic [15:0]      ovf_cnt;
`endif

    operand_stager dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_en_i      (load_en),
        .load_payload_i (load_payload),
        .load_last_i    (load_last),
        .load_rdy_o     (load_rdy),
        .read_en_i      (read_en),
        .pair_valid_o   (pair_valid),
        .h_bus_o        (h_bus),
        .v_bus_o        (v_bus),
        .level_o        (level),
`ifdef STAGER_OVF_CNT_EN
        .ovf_cnt_o      (ovf_cnt),
`endif
        .ovf_o          (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stored pairs as flat 2*ROW_W words, current frame as a word list.
    logic [2*ROW_W-1:0] mq[$];
    logic [IN_W-1:0]    cur[$];
    logic               m_ovf = 1'b0;
    logic [15:0]        m_cnt = '0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [2*ROW_W-1:0] hd;
        hd = (mq.size() > 0) ? mq[0] : '0;
        chk("pair_valid", 512'(pair_valid), 512'(mq.size() > 0));
        chk("level", 512'(level), 512'(mq.size()));
        chk("load_rdy", 512'(load_rdy), 512'(mq.size() < DEPTH));
        chk("ovf", 512'(ovf), 512'(m_ovf));
        chk("h_bus", 512'(h_bus), 512'(hd[ROW_W-1:0]));
        chk("v_bus", 512'(v_bus), 512'(hd[2*ROW_W-1:ROW_W]));
`ifdef STAGER_OVF_CNT_EN
        chk("ovf_cnt", 512'(ovf_cnt), 512'(m_cnt));
`endif
    endtask

    task automatic cycle(input logic en, input logic [IN_W-1:0] d,
                         input logic last, input logic rd);
        logic               rdy;
        logic [2*ROW_W-1:0] p;
        load_en      = en;
        load_payload = d;
        load_last    = last;
        read_en      = rd;
        rdy = (mq.size() < DEPTH);
        if (rd && mq.size() > 0) void'(mq.pop_front());
        if (en && !rdy) begin
            m_ovf = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        if (en && rdy) begin
            cur.push_back(d);
            if (last || cur.size() == 2 * WPR) begin
                p = '0;
                foreach (cur[i]) p[i*IN_W +: IN_W] = cur[i];
                mq.push_back(p);
                cur.delete();
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        load_en = 1'b0;
        load_last = 1'b0;
        read_en = 1'b0;
        load_payload = '0;
        rst_n = 1'b0;
        #2;
        chk("rst pair_valid", 512'(pair_valid), 512'(0));
        chk("rst level", 512'(level), 512'(0));
        chk("rst load_rdy", 512'(load_rdy), 512'(1));
        chk("rst ovf", 512'(ovf), 512'(0));
        chk("rst h_bus", 512'(h_bus), 512'(0));
        chk("rst v_bus", 512'(v_bus), 512'(0));
`ifdef STAGER_OVF_CNT_EN
        chk("rst ovf_cnt", 512'(ovf_cnt), 512'(0));
`endif
        mq.delete();
        cur.delete();
        m_ovf = 1'b0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic            en;
        logic [IN_W-1:0] d;
        logic            last;
        logic            rd;
        int              lvl;
        logic            vld;
        logic            rdy;
    } vec_t;

    vec_t            tbl[21];
    logic [IN_W-1:0] fill_w[64];
    int              maxlvl;

    initial begin
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, IN_W'(i + 1), 1'b0, 1'b0, (i == 15) ? 1 : 0, i == 15, 1'b1};
        tbl[16] = '{1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 32'hA, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 32'hB, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 32'hC, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        tbl[20] = '{1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b1};

        #1;
        do_reset();

        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].en, tbl[i].d, tbl[i].last, tbl[i].rd);
            chk($sformatf("vec%0d level", i), 512'(level), 512'(tbl[i].lvl));
            chk($sformatf("vec%0d valid", i), 512'(pair_valid), 512'(tbl[i].vld));
            chk($sformatf("vec%0d rdy", i), 512'(load_rdy), 512'(tbl[i].rdy));
            if (i == 15) begin
                chk("full h lo", 512'(h_bus[31:0]), 512'(32'h1));
                chk("full h hi", 512'(h_bus[255:224]), 512'(32'h8));
                chk("full v lo", 512'(v_bus[31:0]), 512'(32'h9));
                chk("full v hi", 512'(v_bus[255:224]), 512'(32'h10));
            end
            if (i == 19) begin
                chk("flush h lo", 512'(h_bus[95:0]), 512'({32'hC, 32'hB, 32'hA}));
                chk("flush h hi", 512'(h_bus[255:96]), 512'(0));
                chk("flush v", 512'(v_bus), 512'(0));
            end
        end

        // Fill all four entries, then one extra word must be dropped.
        for (int i = 0; i < 64; i++) begin
            fill_w[i] = $urandom;
            cycle(1'b1, fill_w[i], 1'b0, 1'b0);
        end
        chk("fill level", 512'(level), 512'(4));
        chk("fill rdy", 512'(load_rdy), 512'(0));
        chk("fill ovf pre", 512'(ovf), 512'(0));
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("drop ovf", 512'(ovf), 512'(1));
        chk("drop level", 512'(level), 512'(4));
        chk("drop head", 512'(h_bus[31:0]), 512'(fill_w[0]));
`ifdef STAGER_OVF_CNT_EN
        chk("drop cnt", 512'(ovf_cnt), 512'(1));
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("pop level", 512'(level), 512'(3));
        chk("pop rdy", 512'(load_rdy), 512'(1));
        chk("pop head h", 512'(h_bus[31:0]), 512'(fill_w[16]));
        chk("pop head v", 512'(v_bus[255:224]), 512'(fill_w[31]));
        // Refill to full with four surplus words beyond the pair.
        for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        chk("refill level", 512'(level), 512'(4));
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("drain level", 512'(level), 512'(0));

        // Streaming with read held high.
        do_reset();
        maxlvl = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(1'b1, $urandom, 1'b0, 1'b1);
            if (int'(level) > maxlvl) maxlvl = int'(level);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("stream maxlvl", 512'(maxlvl), 512'(1));
        chk("stream ovf", 512'(ovf), 512'(0));

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hF00 + IN_W'(i), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + IN_W'(i), 1'b0, 1'b0);
        chk("post-rst level", 512'(level), 512'(1));
        chk("post-rst h lo", 512'(h_bus[31:0]), 512'(32'h100));
        chk("post-rst v hi", 512'(v_bus[255:224]), 512'(32'h10F));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 16) == 0, ($urandom % 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
